// File: rtl/fpu_divider.sv
// Sequential IEEE-754 single-precision divider (out = a / b).
// Radix-2 restoring mantissa division, one quotient bit per clock, fixed
// 28-cycle latency from accepted start to the done pulse.
module fpu_divider #(
  parameter int BIAS     = 127,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] out,
  output logic        exception,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

  localparam logic [4:0] LastStep = 5'd25;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [24:0]        rem_q, rem_d;
  logic [25:0]        quo_q, quo_d;
  logic [23:0]        op_b_q, op_b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  e_q, e_d;
  logic               exc_q, exc_d;
  logic               dbz_q, dbz_d;
  logic               azero_q, azero_d;

  logic [31:0]        out_q, out_d;
  logic               exception_q, exception_d;
  logic               div_by_zero_q, div_by_zero_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  // Operand decode; exponent 0 is flushed to zero
  logic [7:0]  ea, eb;
  logic [23:0] op_a, op_b;
  assign ea   = a[30:23];
  assign eb   = b[30:23];
  assign op_a = (ea == 8'd0) ? 24'd0 : {1'b1, a[22:0]};
  assign op_b = (eb == 8'd0) ? 24'd0 : {1'b1, b[22:0]};

  // One restoring-division step
  logic        ge;
  logic [24:0] rem_sub;
  assign ge      = rem_q >= {1'b0, op_b_q};
  assign rem_sub = ge ? (rem_q - {1'b0, op_b_q}) : rem_q;

  // Normalisation, rounding and result selection, evaluated during NORM
  logic signed [9:0] exp_n, exp_r;
  logic [22:0]       mant_n, mant_r;
  logic              guard, sticky, rnd;
  logic [23:0]       mant_sum;
  always_comb begin
    if (quo_q[25]) begin
      mant_n = quo_q[24:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != 25'd0);
      exp_n  = e_q + 10'(BIAS);
    end else begin
      mant_n = quo_q[23:1];
      guard  = quo_q[0];
      sticky = (rem_q != 25'd0);
      exp_n  = e_q + 10'(BIAS) - 10'sd1;
    end
    rnd      = ROUND_EN & guard & sticky;
    mant_sum = {1'b0, mant_n} + {23'd0, rnd};
    if (mant_sum[23]) begin
      mant_r = 23'd0;
      exp_r  = exp_n + 10'sd1;
    end else begin
      mant_r = mant_sum[22:0];
      exp_r  = exp_n;
    end
  end

  // FSM next state, datapath updates and result registration
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    op_b_d        = op_b_q;
    sign_d        = sign_q;
    e_d           = e_q;
    exc_d         = exc_q;
    dbz_d         = dbz_q;
    azero_d       = azero_q;
    out_d         = out_q;
    exception_d   = exception_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StDiv;
          cnt_d   = 5'd0;
          rem_d   = {1'b0, op_a};
          quo_d   = 26'd0;
          op_b_d  = op_b;
          sign_d  = a[31] ^ b[31];
          e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb});
          exc_d   = (ea == 8'hFF) || (eb == 8'hFF);
          dbz_d   = (eb == 8'd0) && (ea != 8'hFF);
          azero_d = (ea == 8'd0);
        end
      end
      StDiv: begin
        rem_d = rem_sub << 1;
        quo_d = {quo_q[24:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastStep) state_d = StNorm;
      end
      StNorm: begin
        state_d       = StDone;
        exception_d   = 1'b0;
        div_by_zero_d = 1'b0;
        overflow_d    = 1'b0;
        underflow_d   = 1'b0;
        if (exc_q) begin
          exception_d = 1'b1;
          out_d       = 32'd0;
        end else if (dbz_q) begin
          div_by_zero_d = 1'b1;
          out_d         = {sign_q, 8'hFF, 23'd0};
        end else if (azero_q) begin
          out_d = {sign_q, 31'd0};
        end else if (exp_r >= 10'sd255) begin
          overflow_d = 1'b1;
          out_d      = {sign_q, 8'hFF, 23'd0};
        end else if (exp_r <= 10'sd0) begin
          underflow_d = 1'b1;
          out_d       = {sign_q, 31'd0};
        end else begin
          out_d = {sign_q, exp_r[7:0], mant_r};
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= 5'd0;
      rem_q         <= 25'd0;
      quo_q         <= 26'd0;
      op_b_q        <= 24'd0;
      sign_q        <= 1'b0;
      e_q           <= 10'sd0;
      exc_q         <= 1'b0;
      dbz_q         <= 1'b0;
      azero_q       <= 1'b0;
      out_q         <= 32'd0;
      exception_q   <= 1'b0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      op_b_q        <= op_b_d;
      sign_q        <= sign_d;
      e_q           <= e_d;
      exc_q         <= exc_d;
      dbz_q         <= dbz_d;
      azero_q       <= azero_d;
      out_q         <= out_d;
      exception_q   <= exception_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  assign ready       = (state_q == StIdle);
  assign done        = (state_q == StDone);
  assign out         = out_q;
  assign exception   = exception_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
